vga_dither_out: RTL



---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_quant2.sv | 23 ++
 rtl/vga_dither_out.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: constants and types shared by the VGA output stage.
//   - BAYER          : 4x4 ordered-dither threshold table, [row = y%4][col = x%4]
//   - bayer_lookup() : table access by the low two bits of vpos/hpos
//   - *_BIT / *_HI / *_LO : bit positions inside the TinyVGA PMOD byte
//   - col2_t         : 2-bit quantised colour channel
package vga_pkg;

   typedef logic [1:0] col2_t;

   localparam logic [3:0] BAYER [4][4] = '{
      '{4'd0,  4'd8,  4'd2,  4'd10},
      '{4'd12, 4'd4,  4'd14, 4'd6 },
      '{4'd3,  4'd11, 4'd1,  4'd9 },
      '{4'd15, 4'd7,  4'd13, 4'd5 }
   };

   // PMOD byte layout {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}.
   // *_HI carries the channel MSB (bit 1), *_LO the LSB (bit 0).
   localparam int HSYNC_BIT = 7;
   localparam int VSYNC_BIT = 3;
   localparam int R_HI      = 0;
   localparam int G_HI      = 1;
   localparam int B_HI      = 2;
   localparam int R_LO      = 4;
   localparam int G_LO      = 5;
   localparam int B_LO      = 6;

   function automatic logic [3:0] bayer_lookup(input logic [1:0] y, input logic [1:0] x);
      return BAYER[y][x];
   endfunction

endpackage

// File: rtl/vga_quant2.sv
// vga_quant2: combinational 8-bit to 2-bit colour quantiser with a 4-bit
// dither threshold.
//   c : 8-bit channel value
//   t : threshold 0..15
//   q : (c*3 + t*16 + 8) >> 8, always 0..3
// The sum peaks at 765 + 240 + 8 = 1013, so 10 bits hold it without
// saturation and the top two bits are the result.
module vga_quant2
   import vga_pkg::*;
(
   input  logic [7:0] c,
   input  logic [3:0] t,
   output col2_t      q
);

   logic [9:0] sum;

   always_comb begin
      sum = ({2'b00, c} * 10'd3) + {2'b00, t, 4'b0000} + 10'd8;
      q   = sum[9:8];
   end

endmodule

// File: rtl/vga_dither_out.sv
// vga_dither_out: output stage driving the TinyVGA PMOD.
// Two register stages; everything sampled at cycle N is on pmod_out at N+2.
//   Stage 1: colour (input or test bars), dither threshold, display_on, syncs.
//   Stage 2: quantised colour, blanking and syncs packed into the PMOD byte.
// Ports:
//   clk, reset                    : pixel clock, synchronous active-high reset
//   hsync_in, vsync_in, display_on: timing from the sync generator (active-high)
//   hpos, vpos                    : current pixel position
//   r_in, g_in, b_in              : 8-bit colour of the current pixel
//   dither_en, temporal_en        : Bayer threshold enable, odd-frame inversion
//   pattern_en                    : replace colour with colour bars
//   pmod_out                      : packed PMOD byte
//   frame_odd                     : frame parity, toggled by each vsync rising edge
// Parameters:
//   INVERT_SYNC : 1 inverts hsync/vsync at the pins
//   BAR_SHIFT   : bar index = hpos[BAR_SHIFT+2:BAR_SHIFT]
module vga_dither_out
   import vga_pkg::*;
#(
   parameter int INVERT_SYNC = 0,
   parameter int BAR_SHIFT   = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       display_on,
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   input  logic [7:0] r_in,
   input  logic [7:0] g_in,
   input  logic [7:0] b_in,
   input  logic       dither_en,
   input  logic       temporal_en,
   input  logic       pattern_en,
   output logic [7:0] pmod_out,
   output logic       frame_odd
);

   // Syncs are stored in true polarity; inversion is a fixed XOR at the pin
   // so every register still clears to 0.
   localparam logic [7:0] SYNC_MASK = (INVERT_SYNC != 0)
      ? ((8'd1 << HSYNC_BIT) | (8'd1 << VSYNC_BIT)) : 8'd0;

   // ---------------- frame parity ----------------
   logic vsync_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_prev <= 1'b0;
         frame_odd  <= 1'b0;
      end else begin
         vsync_prev <= vsync_in;
         if (vsync_in && !vsync_prev)
            frame_odd <= ~frame_odd;
      end
   end

   // ---------------- stage 1 ----------------
   logic [2:0] bar;
   logic [3:0] bayer;
   logic [7:0] r_sel, g_sel, b_sel;
   logic [3:0] t_next;

   always_comb begin
      bar   = hpos[BAR_SHIFT+2 -: 3];
      bayer = bayer_lookup(vpos[1:0], hpos[1:0]);
      if (pattern_en) begin
         r_sel = bar[2] ? 8'd255 : 8'd0;
         g_sel = bar[1] ? 8'd255 : 8'd0;
         b_sel = bar[0] ? 8'd255 : 8'd0;
      end else begin
         r_sel = r_in;
         g_sel = g_in;
         b_sel = b_in;
      end
      if (!dither_en)
         t_next = 4'd8;
      else if (temporal_en && frame_odd)
         t_next = 4'd15 - bayer;
      else
         t_next = bayer;
   end

   logic [7:0] r_s1, g_s1, b_s1;
   logic [3:0] t_s1;
   logic       de_s1, hs_s1, vs_s1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1  <= 8'd0;
         g_s1  <= 8'd0;
         b_s1  <= 8'd0;
         t_s1  <= 4'd0;
         de_s1 <= 1'b0;
         hs_s1 <= 1'b0;
         vs_s1 <= 1'b0;
      end else begin
         r_s1  <= r_sel;
         g_s1  <= g_sel;
         b_s1  <= b_sel;
         t_s1  <= t_next;
         de_s1 <= display_on;
         hs_s1 <= hsync_in;
         vs_s1 <= vsync_in;
      end
   end

   // ---------------- stage 2 ----------------
   col2_t q_r, q_g, q_b;

   vga_quant2 u_quant_r (.c(r_s1), .t(t_s1), .q(q_r));
   vga_quant2 u_quant_g (.c(g_s1), .t(t_s1), .q(q_g));
   vga_quant2 u_quant_b (.c(b_s1), .t(t_s1), .q(q_b));

   logic [7:0] pmod_next;
   logic [7:0] pmod_s2;

   always_comb begin
      pmod_next            = 8'd0;
      pmod_next[HSYNC_BIT] = hs_s1;
      pmod_next[VSYNC_BIT] = vs_s1;
      // Colour is blanked outside the visible area; syncs always pass.
      if (de_s1) begin
         pmod_next[R_HI] = q_r[1];
         pmod_next[G_HI] = q_g[1];
         pmod_next[B_HI] = q_b[1];
         pmod_next[R_LO] = q_r[0];
         pmod_next[G_LO] = q_g[0];
         pmod_next[B_LO] = q_b[0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         pmod_s2 <= 8'd0;
      else
         pmod_s2 <= pmod_next;
   end

   assign pmod_out = pmod_s2 ^ SYNC_MASK;

endmodule
